// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and constants for the bitty sequencer.
//   state_e           - sequencer FSM states
//   br_cond_e         - branch condition codes carried in IR[3:2]
//   FMT_BRANCH        - IR[1:0] encoding of a branch instruction
//   HALT_WORD_DEFAULT - instruction word that stops sequencing
package bitty_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned RET_W    = 16;
    localparam int unsigned COND_LSB = 2;
    localparam int unsigned TGT_LSB  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_MEM  = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    localparam logic [1:0] FMT_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        COND_EQ0   = 2'b00,
        COND_EQ1   = 2'b01,
        COND_EQ2   = 2'b10,
        COND_NEVER = 2'b11
    } br_cond_e;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    // Saturating increment for the retired-instruction counter.
    function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
        return (v == '1) ? v : v + RET_W'(1);
    endfunction

endpackage

// File: rtl/bitty_branch_eval.sv
// bitty_branch_eval: combinational branch condition evaluation.
//   cond_i    - branch condition field (IR[3:2])
//   alu_i     - core's last ALU result
//   taken_o_c - branch taken (combinational)
module bitty_branch_eval
    import bitty_pkg::*;
(
    input  logic [1:0]        cond_i,
    input  logic [DATA_W-1:0] alu_i,
    output logic              taken_o_c
);

    // Conditions 0..2 compare the ALU result against the code value itself.
    always_comb begin
        taken_o_c = 1'b0;
        case (br_cond_e'(cond_i))
            COND_EQ0:   taken_o_c = (alu_i == DATA_W'(0));
            COND_EQ1:   taken_o_c = (alu_i == DATA_W'(1));
            COND_EQ2:   taken_o_c = (alu_i == DATA_W'(2));
            COND_NEVER: taken_o_c = 1'b0;
            default:    taken_o_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetches instructions, hands them to bitty_core one at a
// time, resolves branches locally and counts retired instructions.
//   clk, reset (async, active-low)
//   start, stop                   - run control
//   mem_rd_en, mem_addr, mem_rdata - synchronous instruction memory port
//   core_run, core_instruction    - instruction issue to the core
//   core_done1/2, core_last_alu   - core completion and branch operand
//   busy, halted, fault, pc, retired - status
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        TIMEOUT   = 255,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               core_run,
    output logic [INSTR_W-1:0] core_instruction,
    input  logic               core_done1,
    input  logic               core_done2,
    input  logic [DATA_W-1:0]  core_last_alu,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [ADDR_W-1:0]  pc,
    output logic [RET_W-1:0]   retired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [RET_W-1:0]     retired_q, retired_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic                 core_run_q, core_run_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;

    logic                 br_taken;
    logic [ADDR_W-1:0]    pc_inc;
    logic [CNT_W-1:0]     cnt_inc;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign cnt_inc = cnt_q + CNT_W'(1);

    bitty_branch_eval u_branch_eval (
        .cond_i    (ir_q[COND_LSB +: 2]),
        .alu_i     (core_last_alu),
        .taken_o_c (br_taken)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start && !stop) begin
                    pc_d      = '0;
                    retired_d = '0;
                    fault_d   = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                ir_d    = mem_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (ir_q == HALT_WORD) begin
                    state_d = ST_HALT;
                end else if (ir_q[1:0] == FMT_BRANCH) begin
                    // Target field is truncated to the PC width.
                    pc_d      = br_taken ? ir_q[TGT_LSB +: ADDR_W] : pc_inc;
                    retired_d = sat_inc(retired_q);
                    state_d   = stop ? ST_IDLE : ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done on the final allowed cycle still wins over the timeout.
                if (core_done1 || core_done2) begin
                    pc_d      = pc_inc;
                    retired_d = sat_inc(retired_q);
                    state_d   = stop ? ST_IDLE : ST_FETCH;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode.
        mem_rd_en_d = (state_d == ST_FETCH);
        core_run_d  = (state_d == ST_EXEC);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d    = (state_d == ST_HALT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            retired_q   <= '0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            mem_rd_en_q <= 1'b0;
            core_run_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            retired_q   <= retired_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            mem_rd_en_q <= mem_rd_en_d;
            core_run_q  <= core_run_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_rd_en        = mem_rd_en_q;
    assign mem_addr         = pc_q;
    assign pc               = pc_q;
    assign core_run         = core_run_q;
    assign core_instruction = ir_q;
    assign busy             = busy_q;
    assign halted           = halted_q;
    assign fault            = fault_q;
    assign retired          = retired_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
`timescale 1ns/1ps
// Testbench for bitty_sequencer: memory and core models, directed sequences,
// a branch vector table and randomized programs against an ISA-level model.
module tb_bitty_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned AW2 = 2;
    localparam int unsigned TMO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          core_run;
    logic [15:0]   core_instruction;
    logic          core_done1, core_done2;
    logic [15:0]   core_last_alu;
    logic          busy, halted, fault;
    logic [AW-1:0] pc;
    logic [15:0]   retired;

    logic           start2, stop2;
    logic           mem_rd_en2;
    logic [AW2-1:0] mem_addr2;
    logic [15:0]    mem_rdata2;
    logic           core_run2;
    logic [15:0]    core_instruction2;
    logic           busy2, halted2, fault2;
    logic [AW2-1:0] pc2;
    logic [15:0]    retired2;

    always #5 clk = ~clk;

    bitty_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .core_run(core_run), .core_instruction(core_instruction),
        .core_done1(core_done1), .core_done2(core_done2), .core_last_alu(core_last_alu),
        .busy(busy), .halted(halted), .fault(fault), .pc(pc), .retired(retired)
    );

    // Narrow-PC instance whose core always reports done immediately.
    bitty_sequencer #(.ADDR_W(AW2), .TIMEOUT(TMO)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2),
        .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .core_run(core_run2), .core_instruction(core_instruction2),
        .core_done1(1'b0), .core_done2(1'b1), .core_last_alu(16'd0),
        .busy(busy2), .halted(halted2), .fault(fault2), .pc(pc2), .retired(retired2)
    );

    logic [15:0] mem  [256];
    logic [15:0] mem2 [4];
    always @(posedge clk) if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_en2) mem_rdata2 <= mem2[mem_addr2];

    // Core model: done arrives core_delay cycles after core_run (0 = never);
    // the ALU result advances through alu_seq on every completion.
    int          core_delay;
    bit          rand_delay;
    logic [15:0] alu_seq [64];
    int          alu_idx;
    int          done_cnt;
    assign core_last_alu = alu_seq[alu_idx & 63];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt   <= 0;
            core_done1 <= 1'b0;
            core_done2 <= 1'b0;
            alu_idx    <= 0;
        end else begin
            int d;
            core_done1 <= 1'b0;
            core_done2 <= 1'b0;
            d = done_cnt;
            if (core_run && core_delay != 0)
                d = rand_delay ? int'($urandom_range(1, 4)) : core_delay;
            if (d == 1) begin
                if ($urandom_range(0, 1) == 1) core_done2 <= 1'b1;
                else                           core_done1 <= 1'b1;
                alu_idx  <= alu_idx + 1;
                done_cnt <= 0;
            end else if (d > 1) begin
                done_cnt <= d - 1;
            end else begin
                done_cnt <= 0;
            end
        end
    end

    // Transaction monitor, sampled on the falling edge.
    int cyc = 0;
    int fetch_q[$], fetch_cyc[$], run_cyc[$], fetch2_q[$];
    logic [15:0] run_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_rd_en) begin fetch_q.push_back(int'(mem_addr)); fetch_cyc.push_back(cyc); end
        if (core_run)  begin run_q.push_back(core_instruction); run_cyc.push_back(cyc); end
        if (mem_rd_en2) fetch2_q.push_back(int'(mem_addr2));
    end

    int n_chk = 0;
    int n_pass = 0;
    int exp_fetch[$];
    logic [15:0] exp_run[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_queues();
        fetch_q.delete(); fetch_cyc.delete(); run_q.delete(); run_cyc.delete(); fetch2_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        clear_queues();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        for (int i = 0; i < 64; i++) alu_seq[i] = 16'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_runs(input string name, input int cnt, input int budget);
        int n = 0;
        while (run_q.size() < cnt && n < budget) begin tick(); n++; end
        chk(name, 32'(run_q.size() >= cnt), 32'd1);
    endtask

    // ISA-level reference: walk the program in memory until the halt word.
    task automatic model(output int e_pc, output int e_ret);
        int p = 0, k = 0, r = 0, c;
        logic [15:0] w, a;
        exp_fetch.delete(); exp_run.delete();
        for (int s = 0; s < 300; s++) begin
            exp_fetch.push_back(p);
            w = mem[p];
            if (w == 16'hFFFF) break;
            if (r < 65535) r++;
            if (w[1:0] == 2'b10) begin
                a = alu_seq[k & 63];
                c = int'(w[3:2]);
                p = (c != 3 && int'(a) == c) ? (int'(w) / 16) % 256 : (p + 1) % 256;
            end else begin
                exp_run.push_back(w);
                k++;
                p = (p + 1) % 256;
            end
        end
        e_pc = p;
        e_ret = r;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] alu;
        int          exp_addr;
    } br_vec_t;
    br_vec_t bv[8];

    initial begin
        int e, n, bad, e_pc, e_ret;
        logic [15:0] w;

        bv[0] = '{16'h0052, 16'd0, 5};
        bv[1] = '{16'h0052, 16'd3, 1};
        bv[2] = '{16'h0056, 16'd1, 5};
        bv[3] = '{16'h0056, 16'd2, 1};
        bv[4] = '{16'h005A, 16'd2, 5};
        bv[5] = '{16'h005A, 16'd0, 1};
        bv[6] = '{16'h005E, 16'd0, 1};
        bv[7] = '{16'hABC2, 16'd0, 32'hBC};

        core_delay = 1; rand_delay = 1'b0;
        fill_halt();
        for (int i = 0; i < 4; i++) mem2[i] = 16'hFFFF;

        // Reset values.
        reset = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        tick();
        chk("reset ctrl", 32'({mem_rd_en, core_run, busy, halted, fault}), 32'd0);
        chk("reset pc/addr", 32'({pc, mem_addr}), 32'd0);
        chk("reset instr", 32'(core_instruction), 32'd0);
        chk("reset retired", 32'(retired), 32'd0);

        // Single instruction then halt.
        fill_halt(); mem[0] = 16'h1234; core_delay = 2;
        do_reset();
        pulse_start();
        chk("start->fetch", 32'({mem_rd_en, mem_addr}), 32'h100);
        wait_idle("t1 idle", 100);
        chk("t1 runs", 32'(run_q.size()), 32'd1);
        chk("t1 instr", 32'(run_q[0]), 32'h1234);
        chk("t1 retired", 32'(retired), 32'd1);
        chk("t1 halted", 32'({halted, fault}), 32'b10);
        chk("t1 pc", 32'(pc), 32'd1);
        chk("t1 fetches", 32'(fetch_q.size()), 32'd2);
        chk("t1 fetch->run", 32'(run_cyc[0] - fetch_cyc[0]), 32'd3);
        chk("t1 run->fetch", 32'(fetch_cyc[1] - run_cyc[0]), 32'd3);

        // Branch condition table.
        foreach (bv[i]) begin
            fill_halt(); mem[0] = bv[i].word; alu_seq[0] = bv[i].alu; core_delay = 1;
            do_reset();
            pulse_start();
            wait_idle($sformatf("br%0d idle", i), 100);
            chk($sformatf("br%0d target", i), (fetch_q.size() > 1) ? fetch_q[1] : -1, bv[i].exp_addr);
            chk($sformatf("br%0d no run", i), 32'(run_q.size()), 32'd0);
            chk($sformatf("br%0d retired", i), 32'(retired), 32'd1);
            chk($sformatf("br%0d halted pc", i), 32'({halted, pc}), 32'(256 + bv[i].exp_addr));
            chk($sformatf("br%0d latency", i), (fetch_cyc.size() > 1) ? fetch_cyc[1] - fetch_cyc[0] : -1, 32'd3);
        end

        // Timeout with a core that never completes.
        fill_halt(); mem[0] = 16'h1234; core_delay = 0;
        do_reset();
        pulse_start();
        wait_runs("tmo run", 1, 20);
        e = run_cyc[0];
        n = 0;
        while (!fault && n < 50) begin tick(); n++; end
        chk("tmo fault", 32'(fault), 32'd1);
        chk("tmo latency", 32'(cyc - e), 32'd11);
        chk("tmo idle", 32'({busy, halted}), 32'd0);
        chk("tmo pc", 32'(pc), 32'd0);
        chk("tmo retired", 32'(retired), 32'd0);
        repeat (3) tick();
        chk("tmo sticky", 32'(fault), 32'd1);
        core_delay = 2;
        pulse_start();
        chk("tmo clear on start", 32'(fault), 32'd0);
        wait_idle("tmo rerun idle", 100);
        chk("tmo rerun", 32'({halted, retired}), 32'h10001);

        // Stop during WAIT_DONE; start while busy is ignored.
        fill_halt();
        for (int i = 0; i < 5; i++) mem[i] = 16'(16'h0100 + i * 4);
        core_delay = 2;
        do_reset();
        pulse_start();
        wait_runs("stop run2", 2, 50);
        start = 1'b1; tick(); start = 1'b0;
        wait_runs("stop run3", 3, 50);
        tick();
        stop = 1'b1;
        wait_idle("stop idle", 50);
        chk("stop pc", 32'(pc), 32'd3);
        chk("stop retired", 32'(retired), 32'd3);
        chk("stop not halted", 32'({halted, fault}), 32'd0);
        chk("stop fetch trace", 32'({fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2]}), 32'({32'd3, 32'd0, 32'd1, 32'd2}));
        repeat (4) tick();
        start = 1'b1; repeat (2) tick(); start = 1'b0;
        tick();
        chk("start+stop stays idle", 32'({busy, mem_rd_en}), 32'd0);
        chk("no fetch after stop", 32'(fetch_q.size()), 32'd3);
        stop = 1'b0;

        // PC wrap with a 2-bit address.
        mem2[0] = 16'h0001; mem2[1] = 16'h0004; mem2[2] = 16'h0005; mem2[3] = 16'h0008;
        do_reset();
        start2 = 1'b1; tick(); start2 = 1'b0;
        n = 0;
        while (fetch2_q.size() < 6 && n < 200) begin tick(); n++; end
        stop2 = 1'b1;
        n = 0;
        while (busy2 && n < 50) begin tick(); n++; end
        chk("wrap idle", 32'(busy2), 32'd0);
        chk("wrap trace", 32'({fetch2_q[2], fetch2_q[3], fetch2_q[4], fetch2_q[5]}), 32'({32'd2, 32'd3, 32'd0, 32'd1}));
        chk("wrap retired", 32'(retired2), 32'd6);
        chk("wrap pc", 32'({pc2, fault2}), 32'({2'd2, 1'b0}));
        stop2 = 1'b0;

        // Asynchronous reset in WAIT_DONE, then restart.
        fill_halt(); mem[0] = 16'h0012; mem[1] = 16'h1234; core_delay = 0;
        do_reset();
        pulse_start();
        wait_runs("rst run", 1, 50);
        repeat (2) tick();
        chk("rst pre state", 32'({busy, pc, retired}), 32'({1'b1, 8'd1, 16'd1}));
        reset = 1'b0;
        #1;
        chk("rst async ctrl", 32'({mem_rd_en, core_run, busy, halted, fault}), 32'd0);
        chk("rst async data", 32'({pc, mem_addr, retired}), 32'd0);
        chk("rst async instr", 32'(core_instruction), 32'd0);
        tick();
        reset = 1'b1;
        clear_queues();
        core_delay = 1;
        tick();
        pulse_start();
        chk("rst restart", 32'({mem_rd_en, pc, retired}), 32'h1000000);
        wait_idle("rst restart idle", 100);
        chk("rst restart trace", 32'({fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2]}), 32'({32'd3, 32'd0, 32'd1, 32'd2}));
        chk("rst restart end", 32'({halted, pc, retired}), 32'({1'b1, 8'd2, 16'd2}));

        // Randomized forward-branching programs against the ISA model.
        rand_delay = 1'b1; core_delay = 1;
        for (int t = 0; t < 10; t++) begin
            fill_halt();
            for (int a = 0; a < 16; a++) begin
                if ($urandom_range(0, 99) < 35) begin
                    w = {12'($urandom_range(a + 1, 16)), 2'($urandom_range(0, 3)), 2'b10};
                end else begin
                    w = 16'($urandom);
                    if (w == 16'hFFFF) w = 16'h0001;
                    if (w[1:0] == 2'b10) w[1:0] = 2'b00;
                end
                mem[a] = w;
            end
            for (int i = 0; i < 64; i++)
                alu_seq[i] = ($urandom_range(0, 3) == 3) ? 16'($urandom) : 16'($urandom_range(0, 2));
            model(e_pc, e_ret);
            do_reset();
            pulse_start();
            wait_idle($sformatf("rand%0d idle", t), 2000);
            bad = (fetch_q.size() == exp_fetch.size()) ? -1 : -2;
            for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++)
                if (bad == -1 && fetch_q[i] != exp_fetch[i]) bad = i;
            chk($sformatf("rand%0d fetch trace", t), bad, -1);
            bad = (run_q.size() == exp_run.size()) ? -1 : -2;
            for (int i = 0; i < run_q.size() && i < exp_run.size(); i++)
                if (bad == -1 && run_q[i] != exp_run[i]) bad = i;
            chk($sformatf("rand%0d run trace", t), bad, -1);
            chk($sformatf("rand%0d retired", t), 32'(retired), 32'(e_ret));
            chk($sformatf("rand%0d pc", t), 32'(pc), 32'(e_pc));
            chk($sformatf("rand%0d halted", t), 32'({halted, fault}), 32'b10);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
